// File: rtl/div_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ctrl_if
// Bundles every handshake and data signal around the divider sequencer.
//
// Signal groups:
//   execute side   : ctrl_div, operand_a, operand_b, tag_in, flush, ready_in
//   divider side   : div_dividend, div_divisor, div_start,
//                    div_result, div_overflow, div_ready
//   writeback side : result_valid, result_ack, data_result, data_exception,
//                    result_tag
//
// Modports:
//   slave  : the view taken by div_ctrl itself
//   master : the view taken by the surrounding pipeline (execute stage,
//            divider and writeback), used by the testbench
// -----------------------------------------------------------------------------
interface div_ctrl_if #(
  parameter int TAG_W = 5
);

  logic             ctrl_div;
  logic [31:0]      operand_a;
  logic [31:0]      operand_b;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic             ready_in;

  logic [31:0]      div_dividend;
  logic [31:0]      div_divisor;
  logic             div_start;
  logic [31:0]      div_result;
  logic             div_overflow;
  logic             div_ready;

  logic             result_valid;
  logic             result_ack;
  logic [31:0]      data_result;
  logic             data_exception;
  logic [TAG_W-1:0] result_tag;

  // The sequencer consumes requests, divider status and acks, and drives
  // everything else.
  modport slave (
    input  ctrl_div, operand_a, operand_b, tag_in, flush,
    input  div_result, div_overflow, div_ready,
    input  result_ack,
    output ready_in,
    output div_dividend, div_divisor, div_start,
    output result_valid, data_result, data_exception, result_tag
  );

  // The surrounding pipeline sees the mirror image.
  modport master (
    output ctrl_div, operand_a, operand_b, tag_in, flush,
    output div_result, div_overflow, div_ready,
    output result_ack,
    input  ready_in,
    input  div_dividend, div_divisor, div_start,
    input  result_valid, data_result, data_exception, result_tag
  );

endinterface

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Sequencing front-end for the 32-iteration signed divider. A request from
// the execute stage has its operands and tag latched, the divider is launched
// with a one-cycle div_start pulse, completion is awaited under a 6-bit
// watchdog, and the result is held for writeback until it is acknowledged.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low; clears all state
//   bus   : div_ctrl_if.slave carrying the execute, divider and writeback
//           signal groups
//
// Parameters:
//   TAG_W    : width of the destination-register tag
//   WDOG_MAX : WAIT cycles tolerated before the operation is aborted
//
// Optional feature macro: DIV_CTRL_FASTPATH_EN
//   When defined, divisors 0, 1 and -1 are resolved when the request is
//   latched in IDLE and the block goes straight to DONE without starting the
//   divider. When undefined, every request runs through the divider.
// -----------------------------------------------------------------------------
module div_ctrl #(
  parameter int TAG_W    = 5,
  parameter int WDOG_MAX = 63
) (
  input  logic       clock,
  input  logic       reset,
  div_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [5:0] WDOG_LIM = 6'(WDOG_MAX);

  state_t           r_state;
  state_t           w_stateNext;

  logic [31:0]      r_dividend;
  logic [31:0]      r_divisor;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_result;
  logic             r_exception;
  logic [5:0]       r_wdog;

  logic             w_readyIn;
  logic             w_divStart;
  logic             w_resultValid;
  logic             w_latch;
  logic             w_wdogExpired;

  logic             w_fastHit;
  logic [31:0]      w_fastResult;
  logic             w_fastExc;

  // Trivial-divisor decode. Only the IDLE latch consults it; the default
  // build ties it off so every request is sent to the divider.
`ifdef DIV_CTRL_FASTPATH_EN
  always_comb begin
    w_fastHit    = 1'b0;
    w_fastResult = 32'd0;
    w_fastExc    = 1'b0;
    if (bus.operand_b == 32'd0) begin
      w_fastHit    = 1'b1;
      w_fastResult = 32'd0;
      w_fastExc    = 1'b1;
    end else if (bus.operand_b == 32'd1) begin
      w_fastHit    = 1'b1;
      w_fastResult = bus.operand_a;
      w_fastExc    = 1'b0;
    end else if (bus.operand_b == 32'hFFFF_FFFF) begin
      // Negating the most negative dividend wraps back onto itself, which is
      // the one overflow case of a divide by -1.
      w_fastHit    = 1'b1;
      w_fastResult = (~bus.operand_a) + 32'd1;
      w_fastExc    = (bus.operand_a == 32'h8000_0000);
    end
  end
`else
  assign w_fastHit    = 1'b0;
  assign w_fastResult = 32'd0;
  assign w_fastExc    = 1'b0;
`endif

  // The watchdog trips on the WAIT cycle in which it has already counted the
  // full budget, so the abort lands WDOG_MAX+1 cycles after WAIT entry.
  assign w_wdogExpired = (r_state == WAIT) && (r_wdog >= WDOG_LIM);

  // A new operation is latched either from IDLE or from DONE when the old
  // result is acknowledged in the same cycle. ready_in already folds in the
  // flush priority, so a flushed cycle never latches.
  assign w_latch = bus.ctrl_div && w_readyIn;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. flush overrides everything else; LAUNCH ignores
  // div_ready because it may still be high from the previous operation.
  always_comb begin
    w_stateNext = r_state;
    if (bus.flush) begin
      w_stateNext = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.ctrl_div) begin
            w_stateNext = w_fastHit ? DONE : LAUNCH;
          end
        end
        LAUNCH: begin
          w_stateNext = WAIT;
        end
        WAIT: begin
          if (bus.div_ready || w_wdogExpired) begin
            w_stateNext = DONE;
          end
        end
        DONE: begin
          if (bus.result_ack) begin
            w_stateNext = bus.ctrl_div ? LAUNCH : IDLE;
          end
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  // Output decode. A flush seen in WAIT pulses div_start in that same cycle
  // so the divider is parked while this block returns to IDLE. In DONE the
  // block can only take a new request when the current result is being
  // acknowledged.
  always_comb begin
    w_readyIn     = 1'b0;
    w_divStart    = 1'b0;
    w_resultValid = 1'b0;
    case (r_state)
      IDLE: begin
        w_readyIn = !bus.flush;
      end
      LAUNCH: begin
        w_divStart = 1'b1;
      end
      WAIT: begin
        w_divStart = bus.flush;
      end
      DONE: begin
        w_resultValid = 1'b1;
        w_readyIn     = bus.result_ack && !bus.flush;
      end
      default: begin
        w_readyIn = 1'b0;
      end
    endcase
  end

  // Operand and tag latch. These registers feed the divider directly, so
  // they only move on an accepted request and stay put until the next one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dividend <= 32'd0;
      r_divisor  <= 32'd0;
      r_tag      <= '0;
    end else if (w_latch) begin
      r_dividend <= bus.operand_a;
      r_divisor  <= bus.operand_b;
      r_tag      <= bus.tag_in;
    end
  end

  // Result capture. The divider result is taken when completion is seen in
  // WAIT; a watchdog abort substitutes zero with the exception flag set. The
  // fast path writes its decoded result directly on the IDLE latch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_result    <= 32'd0;
      r_exception <= 1'b0;
    end else if (w_latch && (r_state == IDLE) && w_fastHit) begin
      r_result    <= w_fastResult;
      r_exception <= w_fastExc;
    end else if ((r_state == WAIT) && !bus.flush) begin
      if (bus.div_ready) begin
        r_result    <= bus.div_result;
        r_exception <= bus.div_overflow;
      end else if (w_wdogExpired) begin
        r_result    <= 32'd0;
        r_exception <= 1'b1;
      end
    end
  end

  // Watchdog counter: cleared in LAUNCH, counts every WAIT cycle and
  // saturates at its all-ones value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wdog <= 6'd0;
    end else if (r_state == LAUNCH) begin
      r_wdog <= 6'd0;
    end else if ((r_state == WAIT) && (r_wdog != 6'h3F)) begin
      r_wdog <= r_wdog + 6'd1;
    end
  end

  assign bus.ready_in       = w_readyIn;
  assign bus.div_start      = w_divStart;
  assign bus.div_dividend   = r_dividend;
  assign bus.div_divisor    = r_divisor;
  assign bus.result_valid   = w_resultValid;
  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exception;
  assign bus.result_tag     = r_tag;

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Directed bench for div_ctrl. A small behavioural divider answers each
// div_start with div_ready a fixed 32 cycles later (or never, when told to
// hang). Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

  localparam int TAG_W = 5;

  logic clock;
  logic reset;

  int checkCount;
  int errorCount;
  int startCount;
  int mCnt;
  bit modelHang;

  div_ctrl_if #(.TAG_W(TAG_W)) bus ();

  div_ctrl #(.TAG_W(TAG_W), .WDOG_MAX(63)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Counts div_start pulses as the DUT's registers see them at each edge.
  always @(posedge clock) begin
    if (bus.div_start) startCount++;
  end

  // Behavioural divider: a start pulse clears div_ready and arms a 32-cycle
  // countdown; divide-by-zero reports overflow with a zero quotient.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mCnt             <= 0;
      bus.div_ready    <= 1'b0;
      bus.div_result   <= 32'd0;
      bus.div_overflow <= 1'b0;
    end else if (bus.div_start) begin
      bus.div_ready <= 1'b0;
      mCnt          <= modelHang ? 0 : 31;
      if (bus.div_divisor == 32'd0) begin
        bus.div_result   <= 32'd0;
        bus.div_overflow <= 1'b1;
      end else begin
        bus.div_result   <= $signed(bus.div_dividend) / $signed(bus.div_divisor);
        bus.div_overflow <= 1'b0;
      end
    end else if (mCnt > 0) begin
      mCnt <= mCnt - 1;
      if (mCnt == 1) bus.div_ready <= 1'b1;
    end
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single edge and returns in the LAUNCH cycle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [TAG_W-1:0] tag);
    bus.ctrl_div  = 1'b1;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.tag_in    = tag;
    @(negedge clock);
    bus.ctrl_div  = 1'b0;
  endtask

  // Waits for result_valid with a cycle budget; reports how many cycles it took.
  task automatic waitValid(input int maxCycles, output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (!bus.result_valid && cycles < maxCycles);
  endtask

  // Acknowledges the held result with no new request behind it.
  task automatic ackResult();
    bus.result_ack = 1'b1;
    @(negedge clock);
    bus.result_ack = 1'b0;
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_ready_in"},     32'(bus.ready_in),       32'd1);
    checkOutput({pfx, "_div_start"},    32'(bus.div_start),      32'd0);
    checkOutput({pfx, "_result_valid"}, 32'(bus.result_valid),   32'd0);
    checkOutput({pfx, "_data_result"},  bus.data_result,         32'd0);
    checkOutput({pfx, "_exception"},    32'(bus.data_exception), 32'd0);
    checkOutput({pfx, "_result_tag"},   32'(bus.result_tag),     32'd0);
    checkOutput({pfx, "_dividend"},     bus.div_dividend,        32'd0);
    checkOutput({pfx, "_divisor"},      bus.div_divisor,         32'd0);
  endtask

  initial begin
    int cycles;
    int snap;
    int validSeen;

    checkCount     = 0;
    errorCount     = 0;
    startCount     = 0;
    modelHang      = 1'b0;
    reset          = 1'b0;
    bus.ctrl_div   = 1'b0;
    bus.operand_a  = 32'd0;
    bus.operand_b  = 32'd0;
    bus.tag_in     = '0;
    bus.flush      = 1'b0;
    bus.result_ack = 1'b0;

    repeat (3) @(negedge clock);
    checkResetValues("rst");
    reset = 1'b1;
    @(negedge clock);

    // 100 / 7 = 14, tag 3, result held until acknowledged.
    applyStimulus(32'd100, 32'd7, 5'd3);
    checkOutput("t1_launch_start", 32'(bus.div_start), 32'd1);
    checkOutput("t1_launch_ready", 32'(bus.ready_in), 32'd0);
    checkOutput("t1_dividend", bus.div_dividend, 32'd100);
    checkOutput("t1_divisor", bus.div_divisor, 32'd7);
    snap = startCount;
    waitValid(100, cycles);
    checkOutput("t1_latency", 32'(cycles), 32'd33);
    checkOutput("t1_extra_starts", 32'(startCount - snap), 32'd1);
    checkOutput("t1_result", bus.data_result, 32'd14);
    checkOutput("t1_exception", 32'(bus.data_exception), 32'd0);
    checkOutput("t1_tag", 32'(bus.result_tag), 32'd3);
    repeat (3) @(negedge clock);
    checkOutput("t1_hold_valid", 32'(bus.result_valid), 32'd1);
    checkOutput("t1_hold_result", bus.data_result, 32'd14);
    checkOutput("t1_done_ready_noack", 32'(bus.ready_in), 32'd0);
    bus.result_ack = 1'b1;
    #1;
    checkOutput("t1_done_ready_ack", 32'(bus.ready_in), 32'd1);
    @(negedge clock);
    bus.result_ack = 1'b0;
    checkOutput("t1_idle_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("t1_idle_ready", 32'(bus.ready_in), 32'd1);

    // -100 / 7 = -14, then ack together with a new request of 9 / -3 = -3.
    applyStimulus(32'hFFFF_FF9C, 32'd7, 5'd4);
    waitValid(100, cycles);
    checkOutput("t2a_latency", 32'(cycles), 32'd33);
    checkOutput("t2a_result", bus.data_result, 32'hFFFF_FFF2);
    checkOutput("t2a_tag", 32'(bus.result_tag), 32'd4);
    bus.result_ack = 1'b1;
    bus.ctrl_div   = 1'b1;
    bus.operand_a  = 32'd9;
    bus.operand_b  = 32'hFFFF_FFFD;
    bus.tag_in     = 5'd5;
    @(negedge clock);
    bus.result_ack = 1'b0;
    bus.ctrl_div   = 1'b0;
    checkOutput("t2_b2b_start", 32'(bus.div_start), 32'd1);
    checkOutput("t2_b2b_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("t2_b2b_divisor", bus.div_divisor, 32'hFFFF_FFFD);
    waitValid(100, cycles);
    checkOutput("t2b_latency", 32'(cycles), 32'd33);
    checkOutput("t2b_result", bus.data_result, 32'hFFFF_FFFD);
    checkOutput("t2b_exception", 32'(bus.data_exception), 32'd0);
    checkOutput("t2b_tag", 32'(bus.result_tag), 32'd5);
    ackResult();

    // 5 / 0: divide-by-zero raises the exception.
    snap = startCount;
    applyStimulus(32'd5, 32'd0, 5'd6);
`ifdef DIV_CTRL_FASTPATH_EN
    checkOutput("t3_fast_valid", 32'(bus.result_valid), 32'd1);
    checkOutput("t3_fast_exception", 32'(bus.data_exception), 32'd1);
    checkOutput("t3_fast_result", bus.data_result, 32'd0);
    @(negedge clock);
    checkOutput("t3_fast_no_start", 32'(startCount - snap), 32'd0);
    ackResult();
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
    checkOutput("t3_fast_neg_result", bus.data_result, 32'h8000_0000);
    checkOutput("t3_fast_neg_exception", 32'(bus.data_exception), 32'd1);
    ackResult();
`else
    waitValid(100, cycles);
    checkOutput("t3_latency", 32'(cycles), 32'd33);
    checkOutput("t3_exception", 32'(bus.data_exception), 32'd1);
    checkOutput("t3_result", bus.data_result, 32'd0);
    checkOutput("t3_tag", 32'(bus.result_tag), 32'd6);
    ackResult();
`endif

    // Divider never answers: watchdog aborts 64 cycles after WAIT entry.
    modelHang = 1'b1;
    applyStimulus(32'd1000, 32'd10, 5'd8);
    waitValid(200, cycles);
    checkOutput("t4_wdog_latency", 32'(cycles), 32'd65);
    checkOutput("t4_wdog_result", bus.data_result, 32'd0);
    checkOutput("t4_wdog_exception", 32'(bus.data_exception), 32'd1);
    ackResult();
    modelHang = 1'b0;

    // flush in WAIT cycle 10 with a competing request.
    applyStimulus(32'd77, 32'd11, 5'd10);
    repeat (9) @(negedge clock);
    bus.flush     = 1'b1;
    bus.ctrl_div  = 1'b1;
    bus.operand_a = 32'd1234;
    bus.operand_b = 32'd2;
    bus.tag_in    = 5'd11;
    #1;
    checkOutput("t5_flush_start", 32'(bus.div_start), 32'd1);
    checkOutput("t5_flush_ready", 32'(bus.ready_in), 32'd0);
    snap = startCount;
    @(negedge clock);
    bus.flush    = 1'b0;
    bus.ctrl_div = 1'b0;
    #1;
    checkOutput("t5_flush_pulses", 32'(startCount - snap), 32'd1);
    checkOutput("t5_idle_ready", 32'(bus.ready_in), 32'd1);
    checkOutput("t5_idle_start", 32'(bus.div_start), 32'd0);
    checkOutput("t5_not_latched", bus.div_dividend, 32'd77);
    validSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.result_valid) validSeen++;
    end
    checkOutput("t5_valid_stays_low", 32'(validSeen), 32'd0);

    // Asynchronous reset in the middle of WAIT, then a clean 42 / 6 = 7.
    applyStimulus(32'd50, 32'd5, 5'd12);
    repeat (4) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("async");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    applyStimulus(32'd42, 32'd6, 5'd9);
    waitValid(100, cycles);
    checkOutput("t6_latency", 32'(cycles), 32'd33);
    checkOutput("t6_result", bus.data_result, 32'd7);
    checkOutput("t6_exception", 32'(bus.data_exception), 32'd0);
    checkOutput("t6_tag", 32'(bus.result_tag), 32'd9);
    ackResult();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
